mips_regfile_sb: RTL and testbench

Parametrised MIPS general-purpose register file for the datapath decode stage. It has N combinational read ports, one write port, and same-cycle write-to-read bypass. A per-register busy scoreboard tracks in-flight long-latency results so decode can detect RAW hazards. A debug tap exposes one selectable register for the top level.

---
 rtl/mips_pkg.sv | 12 +
 rtl/mips_reg_scoreboard.sv | 71 +++++++
 rtl/mips_regfile_sb.sv | 82 ++++++++
 tb/tb_mips_regfile_sb.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants.
// Default widths and well-known register indices.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_S0   = 16;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/mips_reg_scoreboard.sv
// Per-register busy scoreboard for RAW hazard detection.
// Tracks in-flight results and a registered count of busy entries.
module mips_reg_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              res_en,
    input  logic [ADDR_W-1:0] res_addr,
    output logic [DEPTH-1:0]  busy,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W:0]   ONE      = (ADDR_W + 1)'(1);

    logic [DEPTH-1:0] busy_nxt;
    logic             res_hit;
    logic             wr_hit;
    logic             inc;
    logic             dec;

    assign res_hit = res_en && (res_addr != ZERO_IDX);
    assign wr_hit  = wr_en && (wr_addr != ZERO_IDX);

    // A reserve on an idle entry adds one; a write that really clears subtracts one.
    assign inc = res_hit && !busy[res_addr];
    assign dec = wr_hit && busy[wr_addr]
                 && !(res_hit && (res_addr == wr_addr));

    // Next busy vector: reserve beats a same-cycle write to the same index.
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < DEPTH; i++) begin
            if (res_hit && (res_addr == ADDR_W'(i))) begin
                busy_nxt[i] = 1'b1;
            end else if (wr_hit && (wr_addr == ADDR_W'(i))) begin
                busy_nxt[i] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Running popcount, stepped by at most one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else begin
            case ({inc, dec})
                2'b10:   busy_cnt <= busy_cnt + ONE;
                2'b01:   busy_cnt <= busy_cnt - ONE;
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS GPR file with write-to-read bypass, busy scoreboard and debug tap.
// Register 0 is hardwired to zero; reads are combinational.
module mips_regfile_sb
    import mips_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_RD  = 2,
    parameter int DBG_REG = REG_S0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           res_en,
    input  logic [ADDR_W-1:0]              res_addr,
    output logic [ADDR_W:0]                busy_cnt,
    output logic [DATA_W-1:0]              dbg_data
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] DBG_IDX  = ADDR_W'(DBG_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_hit;

    assign wr_hit = wr_en && (wr_addr != ZERO_IDX);

    // Storage: index 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    mips_reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .res_en   (res_en),
        .res_addr (res_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic byp;

        assign byp = wr_hit && (wr_addr == rd_addr[k]);

        // Read mux: zero register, then bypass, then storage.
        always_comb begin
            if (rd_addr[k] == ZERO_IDX) begin
                rd_data[k] = '0;
            end else if (byp) begin
                rd_data[k] = wr_data;
            end else begin
                rd_data[k] = regs[rd_addr[k]];
            end
        end

        // A completing write hides the hazard in its own cycle.
        assign rd_busy[k] = busy[rd_addr[k]] & ~byp;
    end

    assign dbg_data = regs[DBG_IDX];

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed testbench for mips_regfile_sb.
// Expected values are hand-computed constants.
module tb_mips_regfile_sb;

    logic             clk;
    logic             rst_n;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [31:0]      wr_data;
    logic             res_en;
    logic [4:0]       res_addr;
    logic [5:0]       busy_cnt;
    logic [31:0]      dbg_data;

    int n_cmp;
    int n_bad;

    mips_regfile_sb #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_RD  (2),
        .DBG_REG (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .res_en   (res_en),
        .res_addr (res_addr),
        .busy_cnt (busy_cnt),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        res_en = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        res_en   = 1'b0;
        res_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 32; i++) begin
            rd_addr[0] = 5'(i);
            rd_addr[1] = 5'(31 - i);
            #1;
            check("rst_rd0", rd_data[0], 32'h0);
            check("rst_rd1", rd_data[1], 32'h0);
            check("rst_busy", {30'b0, rd_busy}, 32'h0);
        end
        check("rst_cnt", {26'b0, busy_cnt}, 32'h0);
        check("rst_dbg", dbg_data, 32'h0);

        // bypass on r16, debug tap shows pre-write value
        @(negedge clk);
        rd_addr[0] = 5'd16;
        rd_addr[1] = 5'd0;
        wr_en      = 1'b1;
        wr_addr    = 5'd16;
        wr_data    = 32'hDEADBEEF;
        #1;
        check("byp_r16", rd_data[0], 32'hDEADBEEF);
        check("dbg_pre", dbg_data, 32'h0);
        tick();
        idle();
        #1;
        check("dbg_post", dbg_data, 32'hDEADBEEF);
        check("rd_r16", rd_data[0], 32'hDEADBEEF);

        // writes to r0 are dropped
        @(negedge clk);
        rd_addr[0] = 5'd0;
        wr_en      = 1'b1;
        wr_addr    = 5'd0;
        wr_data    = 32'h12345678;
        #1;
        check("r0_during", rd_data[0], 32'h0);
        tick();
        idle();
        #1;
        check("r0_after", rd_data[0], 32'h0);
        check("r0_cnt", {26'b0, busy_cnt}, 32'h0);

        // reserve r8, then complete it
        @(negedge clk);
        res_en   = 1'b1;
        res_addr = 5'd8;
        tick();
        idle();
        rd_addr[0] = 5'd8;
        #1;
        check("r8_cnt", {26'b0, busy_cnt}, 32'h1);
        check("r8_busy", {31'b0, rd_busy[0]}, 32'h1);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd8;
        wr_data = 32'h55;
        #1;
        check("r8_busy_wr", {31'b0, rd_busy[0]}, 32'h0);
        check("r8_byp", rd_data[0], 32'h55);
        check("r8_cnt_wr", {26'b0, busy_cnt}, 32'h1);
        tick();
        idle();
        #1;
        check("r8_cnt_done", {26'b0, busy_cnt}, 32'h0);
        check("r8_data", rd_data[0], 32'h55);
        check("r8_busy_done", {31'b0, rd_busy[0]}, 32'h0);

        // reserve and write r9 together: reserve wins
        @(negedge clk);
        res_en     = 1'b1;
        res_addr   = 5'd9;
        wr_en      = 1'b1;
        wr_addr    = 5'd9;
        wr_data    = 32'h99;
        rd_addr[1] = 5'd9;
        tick();
        idle();
        #1;
        check("r9_cnt", {26'b0, busy_cnt}, 32'h1);
        check("r9_busy", {31'b0, rd_busy[1]}, 32'h1);
        check("r9_data", rd_data[1], 32'h99);
        @(negedge clk);
        res_en   = 1'b1;
        res_addr = 5'd9;
        tick();
        idle();
        #1;
        check("r9_waw_cnt", {26'b0, busy_cnt}, 32'h1);
        check("r9_waw_busy", {31'b0, rd_busy[1]}, 32'h1);

        // reserve r3..r5, then async reset mid-cycle
        for (int i = 3; i <= 5; i++) begin
            @(negedge clk);
            res_en   = 1'b1;
            res_addr = 5'(i);
            tick();
            idle();
        end
        #1;
        check("multi_cnt", {26'b0, busy_cnt}, 32'h4);
        rd_addr[0] = 5'd8;
        rd_addr[1] = 5'd5;
        #1;
        check("pre_rst_r8", rd_data[0], 32'h55);
        rst_n = 1'b0;
        #1;
        check("arst_cnt", {26'b0, busy_cnt}, 32'h0);
        check("arst_r8", rd_data[0], 32'h0);
        check("arst_dbg", dbg_data, 32'h0);
        check("arst_busy", {30'b0, rd_busy}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // late writeback to r5 is an ordinary write
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hA5A5A5A5;
        #1;
        check("late_busy", {31'b0, rd_busy[1]}, 32'h0);
        tick();
        idle();
        #1;
        check("late_cnt", {26'b0, busy_cnt}, 32'h0);
        check("late_data", rd_data[1], 32'hA5A5A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
